ysyx_22041207_muldiv_ctrl: RTL and testbench
============================================

# ysyx_22041207_muldiv_ctrl

Sequencing controller for the EX-stage multi-cycle arithmetic units (shared multiplier and divider). It accepts one M-extension operation at a time from the ALU, prepares operands, handshakes with the selected unit, stalls the pipeline while the operation is in flight, and returns a single-cycle result pulse. It also handles flush and the RISC-V divide special cases, so the arithmetic units only ever see well-defined work.

## Interface
- XLEN, 64, datapath width.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  EX stage has an M-op; held until the cycle stall is low.
- req_op  in  3  MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- req_word  in  1  *W variant: 32-bit operation, result sign-extended.
- req_a, req_b  in  XLEN  operands (rs1, rs2).
- flush  in  1  kill the current operation.
- stall  out  1  freeze the pipeline.
- resp_valid  out  1  result pulse.
- resp_data  out  XLEN  result, valid with resp_valid.
- mul_valid / mul_ready  out / in  1  multiplier issue handshake.
- mul_a, mul_b  out  XLEN  prepared operands.
- mul_sign  out  2  {a_signed, b_signed}.
- mul_out_valid  in  1  multiplier done.
- mul_lo, mul_hi  in  XLEN  product halves.
- mul_flush  out  1  abort the multiplier.
- div_valid / div_ready  out / in  1  divider issue handshake.
- div_a, div_b  out  XLEN  prepared operands.
- div_sign  out  1  signed division.
- div_out_valid  in  1  divider done.
- div_quot, div_rem  in  XLEN  quotient and remainder.
- div_flush  out  1  abort the divider.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** on req_valid & ~flush, latch op, word and prepared operands.
  - If the op is DIV/REM and req_b (after word prep) is 0, go to DONE with the special result.
  - If the op is signed DIV/REM with a = most-negative and b = -1, go to DONE with the special result.
  - Otherwise go to ISSUE.
- **ISSUE:** hold mul_valid or div_valid high with stable operands. On ready, go to WAIT.
- **WAIT:** on the selected unit's out_valid, capture the result into the result register and go to DONE.
- **DONE:** resp_valid = ~flush. Next state is IDLE. req_valid is ignored in DONE because it still belongs to the completing instruction.
- **Operand preparation:**
  - Word ops: a and b are sign-extended from bit 31 for signed ops, zero-extended for DIVU/REMU.
  - MULHSU: mul_sign=10. MULH: 11. MULHU and MUL: 00.
- **Result selection:**
  - MUL → lo. MULH* → hi. DIV* → quot. REM* → rem.
  - When req_word is set, the result is sign-extended from bit 31. req_word with MULH* yields sext(lo[31:0]).
- **Special results:**
  - Divide by zero: quotient all-ones, remainder = a.
  - Signed overflow: quotient = a, remainder = 0.
  - Both are computed on the prepared operands, then word sign-extension is applied.
- **Flush:** in any state, next state is IDLE and nothing is captured.
  - mul_flush or div_flush pulses for one cycle when flush arrives in ISSUE or WAIT for that unit.
  - A unit's out_valid arriving in the same cycle as flush is discarded.
- **stall** = (IDLE & req_valid & ~flush) | ISSUE | WAIT.

## Timing
- Reset: state IDLE. stall, resp_valid, mul_valid, div_valid, mul_flush, div_flush = 0. resp_data and the operand outputs = 0.
- resp_data, the operand outputs and the flush outputs are registered. stall and resp_valid are decoded from state plus the inputs listed above.
- Normal path, request accepted at cycle 0:
  - cycle 1: ISSUE; ready seen.
  - cycle 2: WAIT; out_valid seen.
  - cycle 3: DONE; resp_valid=1, stall=0.
- Minimum latency is 3 cycles; ready and out_valid delays add 1:1.
- Special path: request at cycle 0 gives resp_valid at cycle 1, with stall high in cycle 0 only.
- Back-to-back ops: a new request can be accepted in the cycle after DONE.
- Asynchronous reset mid-operation returns to IDLE immediately; the units receive rst directly.

## Structure
- Package ysyx_22041207_muldiv_pkg holds:
  - op encodings (3-bit localparams);
  - the state enum;
  - XLEN-based constants: MOST_NEG, ALL_ONES.
- Sub-module ysyx_22041207_muldiv_fixup is purely combinational and contains:
  - word extension;
  - sign selection;
  - special-case detection and special result;
  - result select and sign-extension.
- The FSM, registers and handshakes stay in muldiv_ctrl.

## Test plan
- MUL a=7, b=-3, mul_ready and out_valid after 1 cycle each → resp_data=0xFFFF_FFFF_FFFF_FFEB at cycle 3; stall high for cycles 0-2.
- DIVW a=0x0000_0001_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF → overflow path, no div_valid, resp_data=0xFFFF_FFFF_8000_0000 at cycle 1.
- REMU a=0x1234, b=0 → no dispatch; resp_data=0x1234 at cycle 1. DIVU with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- MULHSU a=-1, b=2, ready held low 4 cycles → mul_valid and operands stable throughout; mul_sign=10; resp_data=0xFFFF_FFFF_FFFF_FFFF after out_valid.
- Flush during WAIT with out_valid asserted in the same cycle → div_flush pulses one cycle, no resp_valid, state IDLE; the next DIV of 100/7 returns 14.
- rst asserted in ISSUE → within the same cycle, stall=0 and div_valid=0; all outputs read their reset values.

Source files
------------

// File: rtl/ysyx_22041207_muldiv_pkg.sv
// Shared definitions for the M-extension sequencing controller.
// Covers op encodings, FSM states and datapath-width constants.
package ysyx_22041207_muldiv_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};
  // Most-negative 32-bit value as it appears after word sign-extension.
  localparam logic [XLEN-1:0] MOST_NEG_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22041207_muldiv_fixup.sv
// Combinational operand preparation, divide special-case handling and
// result selection for the multiply/divide controller.
module ysyx_22041207_muldiv_fixup
  import ysyx_22041207_muldiv_pkg::*;
(
  input  logic [2:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic [XLEN-1:0] prep_a,
  output logic [XLEN-1:0] prep_b,
  output logic [1:0]      mul_sign,
  output logic            div_sign,
  output logic            is_div,
  output logic            special,
  output logic [XLEN-1:0] special_data,
  input  logic [2:0]      res_op,
  input  logic            res_word,
  input  logic [XLEN-1:0] mul_lo,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem,
  output logic [XLEN-1:0] result
);

  logic            zext;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] sp_quot;
  logic [XLEN-1:0] sp_rem;
  logic [XLEN-1:0] sp_sel;
  logic [XLEN-1:0] res_sel;

  // NOTE: every output of a combinational block gets a default first so
  // no path through the case/if leaves a value held, which would infer a latch.
  always_comb begin
    is_div   = req_op[2];
    div_sign = req_op[2] & ~req_op[0];
    zext     = req_op[2] & req_op[0];
    prep_a   = req_a;
    prep_b   = req_b;
    if (req_word) begin
      prep_a = zext ? {{(XLEN-32){1'b0}}, req_a[31:0]} : sext32(req_a[31:0]);
      prep_b = zext ? {{(XLEN-32){1'b0}}, req_b[31:0]} : sext32(req_b[31:0]);
    end

    mul_sign = 2'b00;
    case (req_op)
      OP_MULH:   mul_sign = 2'b11;
      OP_MULHSU: mul_sign = 2'b10;
      default:   mul_sign = 2'b00;
    endcase

    div_zero = is_div & (prep_b == '0);
    overflow = div_sign & (prep_a == (req_word ? MOST_NEG_W : MOST_NEG))
             & (prep_b == ALL_ONES);
    special  = div_zero | overflow;

    // Divide-by-zero wins over overflow; b cannot be both 0 and -1.
    sp_quot      = div_zero ? ALL_ONES : prep_a;
    sp_rem       = div_zero ? prep_a : '0;
    sp_sel       = req_op[1] ? sp_rem : sp_quot;
    special_data = req_word ? sext32(sp_sel[31:0]) : sp_sel;
  end

  always_comb begin
    res_sel = mul_lo;
    if (res_op[2]) begin
      res_sel = res_op[1] ? div_rem : div_quot;
    end else if (res_op != OP_MUL && !res_word) begin
      res_sel = mul_hi;
    end
    result = res_word ? sext32(res_sel[31:0]) : res_sel;
  end

endmodule

// File: rtl/ysyx_22041207_muldiv_ctrl.sv
// Sequencer for the shared multiplier/divider: accepts one M-op, issues it to
// the selected unit, stalls the pipeline meanwhile and pulses the result.
module ysyx_22041207_muldiv_ctrl
  import ysyx_22041207_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic [1:0]      mul_sign,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_lo,
  input  logic [XLEN-1:0] mul_hi,
  output logic            mul_flush,
  output logic            div_valid,
  input  logic            div_ready,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic            div_sign,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem,
  output logic            div_flush
);

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic            word_q;
  logic            is_div_q;

  logic [XLEN-1:0] fx_a, fx_b, fx_special_data, fx_result;
  logic [1:0]      fx_mul_sign;
  logic            fx_div_sign, fx_is_div, fx_special;

  logic            accept, unit_ready, unit_done, capture, busy;

  ysyx_22041207_muldiv_fixup u_fixup (
    .req_op       (req_op),
    .req_word     (req_word),
    .req_a        (req_a),
    .req_b        (req_b),
    .prep_a       (fx_a),
    .prep_b       (fx_b),
    .mul_sign     (fx_mul_sign),
    .div_sign     (fx_div_sign),
    .is_div       (fx_is_div),
    .special      (fx_special),
    .special_data (fx_special_data),
    .res_op       (op_q),
    .res_word     (word_q),
    .mul_lo       (mul_lo),
    .mul_hi       (mul_hi),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .result       (fx_result)
  );

  always_comb begin
    accept     = (state_q == ST_IDLE) & req_valid & ~flush;
    unit_ready = is_div_q ? div_ready : mul_ready;
    unit_done  = is_div_q ? div_out_valid : mul_out_valid;
    capture    = (state_q == ST_WAIT) & unit_done & ~flush;
    busy       = (state_q == ST_ISSUE) | (state_q == ST_WAIT);

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = fx_special ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (unit_ready) state_d = ST_WAIT;
      ST_WAIT:  if (unit_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;

    // rst gates the decode so a held req_valid cannot raise stall during reset.
    stall      = ~rst & (accept | busy);
    resp_valid = ~rst & (state_q == ST_DONE) & ~flush;
    mul_valid  = (state_q == ST_ISSUE) & ~is_div_q;
    div_valid  = (state_q == ST_ISSUE) & is_div_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      is_div_q  <= 1'b0;
      resp_data <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_sign  <= 2'b00;
      div_a     <= '0;
      div_b     <= '0;
      div_sign  <= 1'b0;
      mul_flush <= 1'b0;
      div_flush <= 1'b0;
    end else begin
      mul_flush <= flush & busy & ~is_div_q;
      div_flush <= flush & busy & is_div_q;
      if (accept) begin
        op_q     <= req_op;
        word_q   <= req_word;
        is_div_q <= fx_is_div;
        if (fx_special) begin
          resp_data <= fx_special_data;
        end else if (fx_is_div) begin
          div_a    <= fx_a;
          div_b    <= fx_b;
          div_sign <= fx_div_sign;
        end else begin
          mul_a    <= fx_a;
          mul_b    <= fx_b;
          mul_sign <= fx_mul_sign;
        end
      end
      if (capture) resp_data <= fx_result;
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_muldiv_ctrl.sv
// Directed bench for the multiply/divide sequencer; expected results are
// queued at issue and popped when resp_valid is observed.
module tb_ysyx_22041207_muldiv_ctrl;
  import ysyx_22041207_muldiv_pkg::*;

  logic            clk, rst;
  logic            req_valid, req_word, flush;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a, req_b;
  logic            stall, resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            mul_valid, mul_ready, mul_out_valid, mul_flush;
  logic [XLEN-1:0] mul_a, mul_b, mul_lo, mul_hi;
  logic [1:0]      mul_sign;
  logic            div_valid, div_ready, div_out_valid, div_flush, div_sign;
  logic [XLEN-1:0] div_a, div_b, div_quot, div_rem;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];
  int lat;

  ysyx_22041207_muldiv_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_word(req_word),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_out_valid(mul_out_valid), .mul_lo(mul_lo),
    .mul_hi(mul_hi), .mul_flush(mul_flush),
    .div_valid(div_valid), .div_ready(div_ready), .div_a(div_a), .div_b(div_b),
    .div_sign(div_sign), .div_out_valid(div_out_valid), .div_quot(div_quot),
    .div_rem(div_rem), .div_flush(div_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag);
    logic [63:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_data"}, resp_data, e);
  endtask

  task automatic wait_resp(input int budget, output int n);
    n = 0;
    while (resp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_op = OP_MUL; req_word = 0; req_a = '0; req_b = '0;
    flush = 0; mul_ready = 0; mul_out_valid = 0; mul_lo = '0; mul_hi = '0;
    div_ready = 0; div_out_valid = 0; div_quot = '0; div_rem = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mul_valid", mul_valid, 0);
    check("rst_div_valid", div_valid, 0);
    check("rst_mul_flush", mul_flush, 0);
    check("rst_div_flush", div_flush, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_div_b", div_b, 0);
    tick(); rst = 1'b0;

    // MUL 7 * -3 with one-cycle ready and out_valid
    tick();
    req_valid = 1; req_op = OP_MUL; req_word = 0; req_a = 64'd7; req_b = 64'hFFFF_FFFF_FFFF_FFFD;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk); check("mul_c0_stall", stall, 1);
    tick(); mul_ready = 1;
    @(negedge clk);
    check("mul_c1_valid", mul_valid, 1);
    check("mul_c1_a", mul_a, 64'd7);
    check("mul_c1_b", mul_b, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul_c1_sign", mul_sign, 2'b00);
    check("mul_c1_stall", stall, 1);
    tick(); mul_ready = 0; mul_out_valid = 1;
    mul_lo = 64'hFFFF_FFFF_FFFF_FFEB; mul_hi = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check("mul_c2_stall", stall, 1);
    check("mul_c2_valid", mul_valid, 0);
    tick(); mul_out_valid = 0;
    @(negedge clk);
    check("mul_c3_stall", stall, 0);
    check_resp("mul_c3");
    tick(); req_valid = 0;
    @(negedge clk); check("mul_c4_resp_valid", resp_valid, 0);

    // DIVW signed overflow: special path, no dispatch
    tick();
    req_valid = 1; req_op = OP_DIV; req_word = 1;
    req_a = 64'h0000_0001_8000_0000; req_b = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_q.push_back(64'hFFFF_FFFF_8000_0000);
    @(negedge clk);
    check("divw_c0_stall", stall, 1);
    check("divw_c0_div_valid", div_valid, 0);
    tick();
    @(negedge clk);
    check_resp("divw_c1");
    check("divw_c1_stall", stall, 0);
    check("divw_c1_div_valid", div_valid, 0);

    // REMU by zero, then DIVU by zero back-to-back
    tick();
    req_valid = 1; req_op = OP_REMU; req_word = 0; req_a = 64'h1234; req_b = '0;
    exp_q.push_back(64'h1234);
    @(negedge clk); check("remu_c0_div_valid", div_valid, 0);
    tick();
    @(negedge clk); check_resp("remu_c1");
    tick(); req_op = OP_DIVU;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); check("divu_c0_stall", stall, 1);
    tick();
    @(negedge clk); check_resp("divu_c1");

    // MULHSU -1 * 2 with ready held low for four ISSUE cycles
    tick();
    req_valid = 1; req_op = OP_MULHSU; req_word = 0; req_a = '1; req_b = 64'd2;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); check("mulhsu_c0_stall", stall, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("mulhsu_hold_valid", mul_valid, 1);
      check("mulhsu_hold_a", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
      check("mulhsu_hold_b", mul_b, 64'd2);
      check("mulhsu_hold_sign", mul_sign, 2'b10);
    end
    tick(); mul_ready = 1;
    @(negedge clk); check("mulhsu_ready_valid", mul_valid, 1);
    tick(); mul_ready = 0; mul_out_valid = 1;
    mul_lo = 64'hFFFF_FFFF_FFFF_FFFE; mul_hi = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); mul_out_valid = 0;
    @(negedge clk); check_resp("mulhsu");
    tick(); req_valid = 0;

    // DIV flushed in WAIT while out_valid arrives in the same cycle
    tick();
    req_valid = 1; req_op = OP_DIV; req_word = 0; req_a = 64'd50; req_b = 64'd5;
    tick(); div_ready = 1;
    @(negedge clk);
    check("flush_issue_valid", div_valid, 1);
    check("flush_issue_a", div_a, 64'd50);
    check("flush_issue_b", div_b, 64'd5);
    check("flush_issue_sign", div_sign, 1);
    tick(); div_ready = 0; flush = 1; div_out_valid = 1; div_quot = 64'd10; div_rem = '0;
    @(negedge clk);
    check("flush_wait_stall", stall, 1);
    check("flush_wait_resp_valid", resp_valid, 0);
    tick(); flush = 0; div_out_valid = 0; req_valid = 0;
    @(negedge clk);
    check("flush_pulse_hi", div_flush, 1);
    check("flush_mul_flush", mul_flush, 0);
    check("flush_after_resp_valid", resp_valid, 0);
    check("flush_after_stall", stall, 0);
    tick();
    @(negedge clk);
    check("flush_pulse_lo", div_flush, 0);
    check("flush_after2_resp_valid", resp_valid, 0);

    // DIV 100 / 7 with the unit responding immediately
    tick();
    req_valid = 1; req_op = OP_DIV; req_word = 0; req_a = 64'd100; req_b = 64'd7;
    div_ready = 1; div_out_valid = 1; div_quot = 64'd14; div_rem = 64'd2;
    exp_q.push_back(64'd14);
    @(negedge clk);
    wait_resp(10, lat);
    check("div100_latency", lat, 3);
    check_resp("div100");
    tick(); req_valid = 0; div_ready = 0; div_out_valid = 0;

    // MULW: upper operand bits ignored, result sign-extended from bit 31
    tick();
    req_valid = 1; req_op = OP_MUL; req_word = 1;
    req_a = 64'hABCD_0000_7FFF_FFFF; req_b = 64'h5555_0000_0000_0002;
    mul_ready = 1; mul_out_valid = 1; mul_lo = 64'h0000_0000_FFFF_FFFE; mul_hi = '0;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    wait_resp(10, lat);
    check("mulw_latency", lat, 3);
    check_resp("mulw");
    check("mulw_a", mul_a, 64'h0000_0000_7FFF_FFFF);
    check("mulw_b", mul_b, 64'd2);
    tick(); req_valid = 0; mul_ready = 0; mul_out_valid = 0;

    // DIVUW: operands zero-extended from bit 31
    tick();
    req_valid = 1; req_op = OP_DIVU; req_word = 1;
    req_a = 64'hFFFF_FFFF_8000_0000; req_b = 64'h1234_0000_0000_0002;
    div_ready = 1; div_out_valid = 1; div_quot = 64'h0000_0000_4000_0000; div_rem = '0;
    exp_q.push_back(64'h0000_0000_4000_0000);
    @(negedge clk);
    wait_resp(10, lat);
    check("divuw_latency", lat, 3);
    check_resp("divuw");
    check("divuw_a", div_a, 64'h0000_0000_8000_0000);
    check("divuw_b", div_b, 64'd2);
    check("divuw_sign", div_sign, 0);
    tick(); req_valid = 0; div_ready = 0; div_out_valid = 0;

    // Asynchronous reset while the divider sits in ISSUE
    tick();
    req_valid = 1; req_op = OP_DIVU; req_word = 0; req_a = 64'd9; req_b = 64'd3;
    @(negedge clk); check("rstiss_c0_stall", stall, 1);
    tick();
    @(negedge clk); check("rstiss_c1_div_valid", div_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rstiss_stall", stall, 0);
    check("rstiss_div_valid", div_valid, 0);
    check("rstiss_resp_valid", resp_valid, 0);
    check("rstiss_div_a", div_a, 0);
    check("rstiss_mul_a", mul_a, 0);
    check("rstiss_resp_data", resp_data, 0);
    tick(); rst = 1'b0; req_valid = 0;
    @(negedge clk); check("rstiss_after_stall", stall, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
